pattern_scan_controller: RTL and testbench
==========================================

Name: pattern_scan_controller

Overview:
- Accepts a parallel data word over a valid/ready handshake and serialises it MSB-first, one bit per clock.
- Runs a programmable serial pattern matcher on the serialised stream, counts matches and reports the count at end of word.
- Sits between a word-producing front end and the serial detector path.
- Owns configuration (pattern, length, overlap mode) and scan sequencing.

Parameters:
- DATA_W, 16: bits per scanned word.
- PAT_MAX, 8: maximum pattern length in bits.
- LEN_W, 4: width of the pattern-length field. Must hold PAT_MAX.
- CNT_W, 5: match counter width.

Ports:
- clk_in, input, 1: clock; all logic on the rising edge.
- reset_in, input, 1: synchronous, active-high reset.
- cfg_we, input, 1: configuration write strobe.
- cfg_pattern, input, PAT_MAX: pattern. Bit 0 is the most recent (last-arriving) bit.
- cfg_len, input, LEN_W: pattern length in bits.
- cfg_overlap, input, 1: 1 = overlapping matches counted; 0 = non-overlapping.
- word_in, input, DATA_W: word to scan.
- word_valid, input, 1: word_in is valid.
- word_ready, output, 1: controller can accept a word.
- busy, output, 1: scan in progress.
- bit_out, output, 1: current serial bit; drives the downstream detector.
- match_pulse, output, 1: one-cycle pulse per counted match.
- match_count, output, CNT_W: matches found in the last or current word.
- done, output, 1: one-cycle end-of-word strobe.

Behaviour:
- Reset values (synchronous, reset_in=1 at a clock edge):
  - state = IDLE.
  - word_ready = 1; busy = bit_out = match_pulse = done = 0; match_count = 0.
  - Pattern register = 0, length = 0, overlap = 1.
  - Reset mid-scan aborts immediately; the word is discarded.
- States: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on word_valid && word_ready. The accept clock edge:
    - latches word_in;
    - clears history, seen counter and match_count;
    - loads bit counter = 0.
  - SHIFT: bit_out = word[DATA_W-1-k] in scan cycle k, for k = 0..DATA_W-1. Advances to DONE after k = DATA_W-1.
  - DONE: lasts one cycle. done = 1. Then returns to IDLE.
- Outputs by state:
  - word_ready = 1 only in IDLE.
  - busy = 1 in SHIFT and DONE.
  - bit_out = 0 outside SHIFT.
- Timing: accept at cycle T; SHIFT occupies T+1..T+DATA_W; DONE at T+DATA_W+1. Back-to-back: next accept possible at T+DATA_W+2.
- Match logic:
  - At the end of each SHIFT cycle the current bit shifts into history bit 0. The seen counter increments, saturating at PAT_MAX.
  - A match occurs when the low L bits of history equal the low L bits of cfg_pattern and seen >= L (L = effective length).
  - The match is registered: match_pulse for bit k is asserted in cycle T+2+k. The pulse for the last bit lands in the DONE cycle.
  - On a match with overlap = 0, the seen counter clears to 0. History is retained.
  - No match spans two words.
- match_count:
  - Increments on each match_pulse and saturates at 2^CNT_W-1.
  - Is final in the DONE cycle and is held until the next accept.
- Configuration:
  - Registered on cfg_we only in IDLE; ignored while busy.
  - If cfg_we and an accept occur in the same cycle, the new configuration applies to that word.
- Length rules:
  - cfg_len = 0 gives no matches.
  - cfg_len > PAT_MAX is clamped to PAT_MAX.

Optional Feature:
- Macro PSC_ABORT_EN.
- When defined:
  - Adds an input port abort_in (1 bit).
  - abort_in = 1 during SHIFT moves the state to IDLE on the next edge. No done pulse is generated.
  - match_count holds its partial value; any match already registered still pulses.
- When undefined: no abort_in port; a scan always runs to DONE.

Test Plan:
- Pattern 4'b1011, len 4, overlap 1, word 16'hB6C0 accepted at T -> match_pulse at T+5, T+8, T+11; done at T+17; match_count = 3.
- Same pattern and word, overlap 0 -> match_pulse at T+5, T+11 only; match_count = 2.
- Pattern 2'b11, len 2, word 16'hFFFF -> count 15 with overlap 1; count 8 with overlap 0. Rerun with CNT_W = 3 -> count saturates at 7.
- Two words with word_valid held high -> word_ready low T..T+17 (except at the accept cycle T); second accept at T+18. bit_out sequence matches both words MSB-first.
- cfg_we with a new pattern during SHIFT -> ignored; the current and next word use the old pattern.
- reset_in at T+6 -> state IDLE, word_ready = 1, match_count = 0 at T+7, no done pulse. With PSC_ABORT_EN, abort_in at T+6 -> IDLE at T+7, count held at 1 (word 16'hB6C0, pattern 1011), no done pulse.

Source files
------------

// File: rtl/pattern_scan_controller.sv
// Word-to-serial scanner with a programmable pattern matcher; DATA_W+2 cycles per word, word_ready only in IDLE.
// Optional PSC_ABORT_EN adds abort_in, which ends a scan early without a done strobe.
module pattern_scan_controller #(
  parameter int DATA_W  = 16,
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 5
) (
  input  logic               clk_in,
  input  logic               reset_in,
`ifdef PSC_ABORT_EN
  input  logic               abort_in,
`endif
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [DATA_W-1:0]  word_in,
  input  logic               word_valid,
  output logic               word_ready,
  output logic               busy,
  output logic               bit_out,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic               done
);

  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [DATA_W-1:0]  sr;
  logic [BC_W-1:0]    bit_cnt;
  logic [PAT_MAX-1:0] hist;
  logic [PAT_MAX-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   seen;
  logic               ovl_r;

  logic [PAT_MAX-1:0] hist_nxt;
  logic [PAT_MAX-1:0] len_mask;
  logic [LEN_W-1:0]   seen_inc;
  logic [LEN_W-1:0]   cfg_len_eff;
  logic               hit;
  logic               abort;

`ifdef PSC_ABORT_EN
  assign abort = abort_in;
`else
  assign abort = 1'b0;
`endif

  assign cfg_len_eff = (cfg_len > LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : cfg_len;
  assign hist_nxt    = {hist[PAT_MAX-2:0], bit_out};
  assign seen_inc    = (seen == LEN_W'(PAT_MAX)) ? seen : seen + 1'b1;

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      len_mask[i] = (i < int'(len_r));
    end
  end

  // seen_inc guards against matching on history left over from before the last clear
  assign hit = (len_r != '0) && (((hist_nxt ^ pat_r) & len_mask) == '0) && (seen_inc >= len_r);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state       <= IDLE;
      word_ready  <= 1'b1;
      busy        <= 1'b0;
      bit_out     <= 1'b0;
      match_pulse <= 1'b0;
      match_count <= '0;
      done        <= 1'b0;
      pat_r       <= '0;
      len_r       <= '0;
      ovl_r       <= 1'b1;
      hist        <= '0;
      seen        <= '0;
      sr          <= '0;
      bit_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done        <= 1'b0;
          match_pulse <= 1'b0;
          if (cfg_we) begin
            pat_r <= cfg_pattern;
            len_r <= cfg_len_eff;
            ovl_r <= cfg_overlap;
          end
          if (word_valid && word_ready) begin
            state       <= SHIFT;
            word_ready  <= 1'b0;
            busy        <= 1'b1;
            sr          <= word_in;
            bit_out     <= word_in[DATA_W-1];
            hist        <= '0;
            seen        <= '0;
            match_count <= '0;
            bit_cnt     <= '0;
          end
        end
        SHIFT: begin
          if (abort) begin
            state       <= IDLE;
            word_ready  <= 1'b1;
            busy        <= 1'b0;
            bit_out     <= 1'b0;
            match_pulse <= 1'b0;
          end else begin
            hist        <= hist_nxt;
            match_pulse <= hit;
            if (hit && (match_count != '1)) match_count <= match_count + 1'b1;
            seen        <= (hit && !ovl_r) ? '0 : seen_inc;
            sr          <= sr << 1;
            bit_out     <= sr[DATA_W-2];
            bit_cnt     <= bit_cnt + 1'b1;
            if (bit_cnt == BC_W'(DATA_W-1)) begin
              state   <= DONE;
              done    <= 1'b1;
              bit_out <= 1'b0;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          done        <= 1'b0;
          busy        <= 1'b0;
          word_ready  <= 1'b1;
          match_pulse <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_controller.sv
// Randomised self-checking bench for pattern_scan_controller against a sliding-window match model.
module tb_pattern_scan_controller;

  localparam int DW = 16;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        cfg_we;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic [15:0] word_in;
  logic        word_valid;
`ifdef PSC_ABORT_EN
  logic        abort_in = 1'b0;
`endif

  logic       word_ready, busy, bit_out, match_pulse, done;
  logic [4:0] match_count;
  logic       s_word_ready, s_busy, s_bit_out, s_match_pulse, s_done;
  logic [2:0] s_match_count;

  int checks = 0;
  int passes = 0;

  logic [7:0] cur_pat;
  int         cur_len;
  logic       cur_ovl;

  always #5 clk_in = ~clk_in;

  pattern_scan_controller dut (
    .clk_in(clk_in), .reset_in(reset_in),
`ifdef PSC_ABORT_EN
    .abort_in(abort_in),
`endif
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready), .busy(busy),
    .bit_out(bit_out), .match_pulse(match_pulse), .match_count(match_count), .done(done)
  );

  pattern_scan_controller #(.CNT_W(3)) u_sat (
    .clk_in(clk_in), .reset_in(reset_in),
`ifdef PSC_ABORT_EN
    .abort_in(abort_in),
`endif
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .word_in(word_in), .word_valid(word_valid), .word_ready(s_word_ready), .busy(s_busy),
    .bit_out(s_bit_out), .match_pulse(s_match_pulse), .match_count(s_match_count), .done(s_done)
  );

  // Bit k of the result is set when a counted match ends on scan bit k.
  function automatic logic [15:0] model_hits(logic [15:0] w, logic [7:0] p, int len, logic ovl);
    logic [15:0] hits = '0;
    int          start = 0;
    logic        ok;
    for (int k = 0; k < DW; k++) begin
      if (len > 0 && (k - start + 1) >= len) begin
        ok = 1'b1;
        for (int j = 0; j < len; j++)
          if (w[DW-1-(k-j)] != p[j]) ok = 1'b0;
        if (ok) begin
          hits[k] = 1'b1;
          if (!ovl) start = k + 1;
        end
      end
    end
    return hits;
  endfunction

  // Called in the low clock phase; the following rising edge is the accept edge (cycle T).
  task automatic scan_word(input logic [15:0] w, input logic [7:0] p, input logic [3:0] l,
                           input logic o, input logic wr_cfg, input logic keep,
                           input logic disturb, input string name, output int final_cnt);
    logic [15:0] hits;
    int          cnt;
    logic        exp_mp, exp_bit;
    logic [4:0]  exp_st;
    if (wr_cfg) begin
      cur_pat = p; cur_len = (int'(l) > 8) ? 8 : int'(l); cur_ovl = o;
      cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    end
    word_in = w; word_valid = 1'b1;
    checks++;
    if (word_ready !== 1'b1) $display("FAIL %s ready_at_accept got %b exp 1", name, word_ready);
    else passes++;
    hits = model_hits(w, cur_pat, cur_len, cur_ovl);
    cnt = 0;
    @(posedge clk_in); #1;
    cfg_we = 1'b0;
    if (!keep) word_valid = 1'b0;
    for (int c = 1; c <= DW + 1; c++) begin
      @(negedge clk_in);
      exp_mp  = (c >= 2) && hits[c-2];
      if (exp_mp) cnt++;
      exp_bit = (c <= DW) ? w[DW-c] : 1'b0;
      exp_st  = {1'b0, 1'b1, exp_bit, exp_mp, (c == DW + 1)};
      checks++;
      if ({word_ready, busy, bit_out, match_pulse, done} !== exp_st ||
          {s_word_ready, s_busy, s_bit_out, s_match_pulse, s_done} !== exp_st)
        $display("FAIL %s status cyc %0d got %b/%b exp %b", name, c,
                 {word_ready, busy, bit_out, match_pulse, done},
                 {s_word_ready, s_busy, s_bit_out, s_match_pulse, s_done}, exp_st);
      else passes++;
      checks++;
      if (match_count !== 5'(cnt) || s_match_count !== 3'((cnt > 7) ? 7 : cnt))
        $display("FAIL %s count cyc %0d got %0d/%0d exp %0d", name, c, match_count, s_match_count, cnt);
      else passes++;
      if (disturb && c == 5) begin
        cfg_we = 1'b1; cfg_pattern = ~cur_pat; cfg_len = 4'($urandom_range(1, 8)); cfg_overlap = ~cur_ovl;
      end
      if (disturb && c == 6) cfg_we = 1'b0;
    end
    @(negedge clk_in);
    checks++;
    if ({word_ready, busy, bit_out, match_pulse, done} !== 5'b10000 || match_count !== 5'(cnt) ||
        s_match_count !== 3'((cnt > 7) ? 7 : cnt))
      $display("FAIL %s idle_hold got st %b cnt %0d/%0d exp st 10000 cnt %0d", name,
               {word_ready, busy, bit_out, match_pulse, done}, match_count, s_match_count, cnt);
    else passes++;
    final_cnt = int'(match_count);
  endtask

  task automatic test_reset();
    reset_in = 1'b1; cfg_we = 1'($urandom); word_valid = 1'($urandom);
    word_in = 16'($urandom); cfg_pattern = 8'($urandom); cfg_len = 4'($urandom); cfg_overlap = 1'($urandom);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checks++;
    if ({word_ready, busy, bit_out, match_pulse, done} !== 5'b10000 || match_count !== 5'd0)
      $display("FAIL reset_state got st %b cnt %0d exp st 10000 cnt 0",
               {word_ready, busy, bit_out, match_pulse, done}, match_count);
    else passes++;
    reset_in = 1'b0; cfg_we = 1'b0; word_valid = 1'b0;
    cur_pat = 8'h00; cur_len = 0; cur_ovl = 1'b1;
  endtask

  task automatic test_default_cfg();
    int n;
    scan_word(16'($urandom), 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, "len0_default", n);
    checks++;
    if (n !== 0) $display("FAIL len0_default final got %0d exp 0", n);
    else passes++;
  endtask

  task automatic test_directed();
    int n;
    scan_word(16'hB6C0, 8'h0B, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, "b6c0_ovl", n);
    checks++; if (n !== 3) $display("FAIL b6c0_ovl final got %0d exp 3", n); else passes++;
    scan_word(16'hB6C0, 8'h0B, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, "b6c0_novl", n);
    checks++; if (n !== 2) $display("FAIL b6c0_novl final got %0d exp 2", n); else passes++;
    scan_word(16'hFFFF, 8'h03, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, "ones_ovl", n);
    checks++; if (n !== 15) $display("FAIL ones_ovl final got %0d exp 15", n); else passes++;
    scan_word(16'hFFFF, 8'h03, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, "ones_novl", n);
    checks++; if (n !== 8) $display("FAIL ones_novl final got %0d exp 8", n); else passes++;
    scan_word(16'hFFFF, 8'hFF, 4'd12, 1'b1, 1'b1, 1'b0, 1'b0, "len_clamp", n);
    checks++; if (n !== 9) $display("FAIL len_clamp final got %0d exp 9", n); else passes++;
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 24; i++)
      scan_word(16'($urandom), 8'($urandom), 4'($urandom_range(0, 10)), 1'($urandom),
                1'($urandom_range(0, 3) != 0), 1'b0, 1'b0, "random", n);
  endtask

  task automatic test_back_to_back();
    int n;
    scan_word(16'($urandom), 8'($urandom), 4'($urandom_range(1, 4)), 1'b1, 1'b1, 1'b1, 1'b0, "b2b_first", n);
    scan_word(16'($urandom), 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_second", n);
  endtask

  task automatic test_cfg_ignored();
    int n;
    scan_word(16'($urandom), 8'h05, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, "cfg_busy", n);
    scan_word(16'($urandom), 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "cfg_after", n);
  endtask

  task automatic test_reset_mid();
    logic seen_bad = 1'b0;
    cfg_we = 1'b1; cfg_pattern = 8'h0B; cfg_len = 4'd4; cfg_overlap = 1'b1;
    word_in = 16'hB6C0; word_valid = 1'b1;
    @(posedge clk_in); #1;
    cfg_we = 1'b0; word_valid = 1'b0;
    for (int c = 1; c <= 6; c++) @(negedge clk_in);
    checks++;
    if (match_count !== 5'd1) $display("FAIL rst_mid pre got %0d exp 1", match_count);
    else passes++;
    reset_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({word_ready, busy, bit_out, match_pulse, done} !== 5'b10000 || match_count !== 5'd0)
      $display("FAIL rst_mid after got st %b cnt %0d exp st 10000 cnt 0",
               {word_ready, busy, bit_out, match_pulse, done}, match_count);
    else passes++;
    reset_in = 1'b0;
    repeat (20) begin
      @(negedge clk_in);
      if (done || busy) seen_bad = 1'b1;
    end
    checks++;
    if (seen_bad !== 1'b0) $display("FAIL rst_mid quiet got %b exp 0", seen_bad);
    else passes++;
    cur_pat = 8'h00; cur_len = 0; cur_ovl = 1'b1;
  endtask

`ifdef PSC_ABORT_EN
  task automatic test_abort();
    logic seen_bad = 1'b0;
    cfg_we = 1'b1; cfg_pattern = 8'h0B; cfg_len = 4'd4; cfg_overlap = 1'b1;
    word_in = 16'hB6C0; word_valid = 1'b1;
    @(posedge clk_in); #1;
    cfg_we = 1'b0; word_valid = 1'b0;
    cur_pat = 8'h0B; cur_len = 4; cur_ovl = 1'b1;
    for (int c = 1; c <= 6; c++) @(negedge clk_in);
    abort_in = 1'b1;
    @(negedge clk_in);
    abort_in = 1'b0;
    checks++;
    if ({word_ready, busy, bit_out, done} !== 4'b1000 || match_count !== 5'd1)
      $display("FAIL abort after got st %b cnt %0d exp st 1000 cnt 1",
               {word_ready, busy, bit_out, done}, match_count);
    else passes++;
    repeat (20) begin
      @(negedge clk_in);
      if (done || busy || match_count != 5'd1) seen_bad = 1'b1;
    end
    checks++;
    if (seen_bad !== 1'b0) $display("FAIL abort quiet got %b exp 0", seen_bad);
    else passes++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default_cfg();
    test_directed();
    test_random();
    test_back_to_back();
    test_cfg_ignored();
    test_reset_mid();
`ifdef PSC_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
